// File: rtl/seg7_display_arbiter.sv
// Round-robin arbiter sharing one four-digit seven-segment display.
// Granted value is latched, multiplexed per digit and hex-decoded.
module seg7_display_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int REFRESH_DIV  = 50_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   busy,
    output logic [3:0]             an,
    output logic [7:0]             seg
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYCLES - 1);
    localparam logic [RW-1:0] REF_MAX   = RW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PTR_RST   = PW'(NUM_REQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  w_gnt_nxt;
    logic [PW-1:0]       r_rr_ptr;
    logic [PW-1:0]       w_rr_nxt;
    logic [DW-1:0]       r_dwell;
    logic [DW-1:0]       w_dwell_nxt;
    logic [15:0]         r_disp;
    logic [RW-1:0]       r_ref_cnt;
    logic [1:0]          r_digit_sel;

    logic [NUM_REQ-1:0]  w_mask;
    logic                w_pick_vld;
    logic [PW-1:0]       w_pick_idx;
    logic                w_held;
    logic                w_expire;
    logic                w_tick;
    logic [15:0]         w_sel_data;
    logic [3:0]          w_nib;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Excluding the current holder makes one search serve idle, drop and expiry.
    assign w_mask   = req & ~r_gnt;
    assign w_held   = req[r_rr_ptr];
    assign w_expire = (r_dwell == DWELL_MAX);

    always_comb begin
        int k;
        k          = 0;
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            k = int'(r_rr_ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (w_mask[k]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = PW'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_rr_ptr <= PTR_RST;
            r_dwell  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_dwell  <= w_dwell_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_rr_nxt    = r_rr_ptr;
        w_dwell_nxt = r_dwell;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt            = HOLD;
                    w_gnt_nxt              = '0;
                    w_gnt_nxt[w_pick_idx]  = 1'b1;
                    w_rr_nxt               = w_pick_idx;
                    w_dwell_nxt            = '0;
                end
            end
            default: begin
                if (!w_held || w_expire) begin
                    w_dwell_nxt = '0;
                    if (w_pick_vld) begin
                        w_gnt_nxt             = '0;
                        w_gnt_nxt[w_pick_idx] = 1'b1;
                        w_rr_nxt              = w_pick_idx;
                    end else if (!w_held) begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + DW'(1);
                end
            end
        endcase
    end

    assign w_sel_data = data[16*int'(r_rr_ptr) +: 16];
    assign w_tick     = (r_ref_cnt == REF_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp      <= 16'h0;
            r_ref_cnt   <= '0;
            r_digit_sel <= 2'd0;
        end else begin
            if (|r_gnt) r_disp <= w_sel_data;
            r_ref_cnt <= w_tick ? '0 : r_ref_cnt + RW'(1);
            if (w_tick) r_digit_sel <= r_digit_sel + 2'd1;
        end
    end

    always_comb begin
        case (r_digit_sel)
            2'd0:    w_nib = r_disp[3:0];
            2'd1:    w_nib = r_disp[7:4];
            2'd2:    w_nib = r_disp[11:8];
            default: w_nib = r_disp[15:12];
        endcase
        gnt  = r_gnt;
        busy = (r_state == HOLD);
        an   = 4'hF;
        seg  = 8'hFF;
        if (busy) begin
            an  = ~(4'b0001 << r_digit_sel);
            seg = hex7(w_nib) | 8'h80;
        end
    end

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Bench for seg7_display_arbiter: directed tables plus random traffic
// checked each cycle against a cycle-count based reference model.
module tb_seg7_display_arbiter;

    localparam int NR = 4;
    localparam int DWC = 8;
    localparam int RD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] data = '0;
    logic [3:0]  gnt;
    logic        busy;
    logic [3:0]  an;
    logic [7:0]  seg;

    seg7_display_arbiter #(
        .NUM_REQ(NR),
        .DWELL_CYCLES(DWC),
        .REFRESH_DIV(RD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .data(data),
        .gnt(gnt),
        .busy(busy),
        .an(an),
        .seg(seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] nib;
        logic [7:0] seg;
    } hexvec_t;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
    } digvec_t;

    hexvec_t hv[16];
    digvec_t dv[4];
    logic [7:0] hex_tab[16];

    int checks = 0;
    int errors = 0;

    // Reference model: grant owner (-1 idle), last grantee, time held, edges since reset.
    int          m_g;
    int          m_last;
    int          m_age;
    int          m_n;
    logic [15:0] m_disp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input int last, input logic [3:0] mask);
        for (int i = 1; i <= NR; i++) begin
            if (mask[(last + i) % NR]) return (last + i) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_g = -1;
        m_last = NR - 1;
        m_age = 0;
        m_n = 0;
        m_disp = 16'h0;
    endtask

    task automatic model_step();
        logic [3:0] others;
        int p;
        m_n++;
        if (m_g < 0) begin
            if (req != 0) begin
                m_g = pick(m_last, req);
                m_last = m_g;
                m_age = 0;
            end
        end else begin
            m_disp = data[16*m_g +: 16];
            if (!req[m_g]) begin
                p = pick(m_last, req);
                if (p < 0) begin
                    m_g = -1;
                end else begin
                    m_g = p;
                    m_last = p;
                    m_age = 0;
                end
            end else if (m_age == DWC - 1) begin
                others = req;
                others[m_g] = 1'b0;
                if (others != 0) begin
                    m_g = pick(m_last, others);
                    m_last = m_g;
                end
                m_age = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic check_model();
        logic [3:0] e_gnt;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        logic [3:0] one;
        int dig;
        dig = (m_n / RD) % 4;
        one = 4'b0001 << dig;
        e_gnt = 4'h0;
        e_an = 4'hF;
        e_seg = 8'hFF;
        if (m_g >= 0) begin
            e_gnt = 4'b0001 << m_g;
            e_an = ~one;
            e_seg = hex_tab[m_disp[4*dig +: 4]];
        end
        chk("gnt", {28'h0, gnt}, {28'h0, e_gnt});
        chk("busy", {31'h0, busy}, {31'h0, (m_g >= 0)});
        chk("an", {28'h0, an}, {28'h0, e_an});
        chk("seg", {24'h0, seg}, {24'h0, e_seg});
    endtask

    task automatic cyc(input logic [3:0] r, input logic [63:0] d);
        req = r;
        data = d;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        req = '0;
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        for (int i = 0; i < 16; i++) begin
            hv[i].nib = 4'(i);
            hv[i].seg = hex_tab[i];
        end
        dv[0] = '{an: 4'b1110, seg: 8'h8E};
        dv[1] = '{an: 4'b1101, seg: 8'h88};
        dv[2] = '{an: 4'b1011, seg: 8'hA4};
        dv[3] = '{an: 4'b0111, seg: 8'hF9};
        model_reset();

        // Reset values, then idle with no requests.
        #3;
        chk("rst_gnt", {28'h0, gnt}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_an", {28'h0, an}, 32'hF);
        chk("rst_seg", {24'h0, seg}, 32'hFF);
        do_reset();
        for (int j = 0; j < 12; j++) begin
            cyc(4'b0000, 64'h0);
            chk("idle_an", {28'h0, an}, 32'hF);
            chk("idle_seg", {24'h0, seg}, 32'hFF);
        end

        // Single requester 0 showing 12AF, digits scanned in order.
        do_reset();
        cyc(4'b0001, 64'h12AF);
        chk("first_gnt", {28'h0, gnt}, 32'h1);
        for (int j = 0; j < 16; j++) begin
            cyc(4'b0001, 64'h12AF);
            if (m_n >= 2 && (m_n % RD) == 0) begin
                chk("digit_an", {28'h0, an}, {28'h0, dv[(m_n / RD) % 4].an});
                chk("digit_seg", {24'h0, seg}, {24'h0, dv[(m_n / RD) % 4].seg});
            end
        end

        // Round robin over requesters 0, 1, 3 with exact dwell.
        do_reset();
        for (int j = 0; j < 32; j++) begin
            logic [3:0] seq[4];
            seq = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
            cyc(4'b1011, {$urandom, $urandom});
            chk("rr_gnt", {28'h0, gnt}, {28'h0, seq[j / DWC]});
        end

        // Lone requester 2 keeps the grant across several expiries.
        do_reset();
        for (int j = 0; j < 3 * DWC + 1; j++) begin
            cyc(4'b0100, 64'h0000_1234_0000_0000);
            chk("solo_gnt", {28'h0, gnt}, 32'h4);
        end

        // Drop mid-dwell hands over immediately; dropping all goes idle.
        do_reset();
        cyc(4'b0011, 64'h0);
        cyc(4'b0011, 64'h0);
        cyc(4'b0011, 64'h0);
        chk("pre_drop_gnt", {28'h0, gnt}, 32'h1);
        cyc(4'b0010, 64'h0);
        chk("drop_gnt", {28'h0, gnt}, 32'h2);
        cyc(4'b0000, 64'h0);
        chk("drop_all_gnt", {28'h0, gnt}, 32'h0);
        chk("drop_all_an", {28'h0, an}, 32'hF);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        cyc(4'b0100, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(4'b0100, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(4'b0100, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("hold_gnt", {28'h0, gnt}, 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_gnt", {28'h0, gnt}, 32'h0);
        chk("async_busy", {31'h0, busy}, 32'h0);
        chk("async_an", {28'h0, an}, 32'hF);
        chk("async_seg", {24'h0, seg}, 32'hFF);
        req = 4'b0101;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cyc(4'b0101, 64'h0);
        chk("post_rst_gnt", {28'h0, gnt}, 32'h1);

        // Hex decode table, every digit carrying the same nibble.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < 3; c++) cyc(4'b0001, {48'h0, {4{hv[i].nib}}});
            chk("hex_seg", {24'h0, seg}, {24'h0, hv[i].seg});
        end

        // Random traffic against the model.
        do_reset();
        begin
            logic [3:0] r;
            r = 4'($urandom);
            for (int j = 0; j < 800; j++) begin
                if ($urandom_range(0, 11) == 0) r = 4'($urandom);
                cyc(r, {$urandom, $urandom});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
